// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared state encoding and default widths for the GA generation controller
package ga_pkg;

  localparam int INT8_LENGTH_DEFAULT    = 8;
  localparam int IND_FIT_LENGTH_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_XOVER = 3'd3,
    ST_MUT   = 3'd4,
    ST_DONE  = 3'd5
  } ga_state_t;

endpackage

// File: rtl/ga_min_tracker.sv
// rtl/ga_min_tracker.sv - running minimum fitness and its index; ties keep the earlier holder
module ga_min_tracker #(
  parameter int IDX_W = 8,
  parameter int FIT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_upd,
  input  logic [FIT_W-1:0] i_fit,
  input  logic [IDX_W-1:0] i_idx,
  output logic [FIT_W-1:0] o_min,
  output logic [IDX_W-1:0] o_argmin
);

  // clear arms the tracker with the worst possible fitness; strict compare keeps the first minimum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_min    <= '0;
      o_argmin <= '0;
    end else if (i_clear) begin
      o_min    <= '1;
      o_argmin <= '0;
    end else if (i_upd && (i_fit < o_min)) begin
      o_min    <= i_fit;
      o_argmin <= i_idx;
    end
  end

endmodule

// File: rtl/ga_gen_ctrl.sv
// rtl/ga_gen_ctrl.sv - GA generation sequencer (load, eval, crossover, mutation); GA_ELITISM_EN skips best_idx in XOVER/MUT
module ga_gen_ctrl
  import ga_pkg::*;
#(
  parameter int INT8_LENGTH    = INT8_LENGTH_DEFAULT,
  parameter int IND_FIT_LENGTH = IND_FIT_LENGTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INT8_LENGTH-1:0]    Num_generations,
  input  logic [INT8_LENGTH-1:0]    Pop_size,
  input  logic [INT8_LENGTH-1:0]    crossoverFraction,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic                      eval_req,
  output logic [INT8_LENGTH-1:0]    eval_idx,
  input  logic                      eval_ack,
  input  logic [IND_FIT_LENGTH-1:0] eval_fit,
  output logic                      xover_req,
  output logic [INT8_LENGTH-1:0]    xover_idx,
  input  logic                      xover_ack,
  output logic                      mut_req,
  output logic [INT8_LENGTH-1:0]    mut_idx,
  input  logic                      mut_ack,
  output logic                      busy,
  output logic                      done,
  output logic [INT8_LENGTH-1:0]    gen_cnt,
  output logic [IND_FIT_LENGTH-1:0] Min_fit_out,
  output logic [INT8_LENGTH-1:0]    best_idx
);

  localparam int W = INT8_LENGTH;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  ga_state_t      r_state;
  logic [W-1:0]   r_num_gen;
  logic [W-1:0]   r_pop;
  logic [W-1:0]   r_xfrac;
  logic [W-1:0]   r_cnt;     // items completed in the current phase / load beats
  logic [W-1:0]   r_idx;     // next candidate index before any elitism skip

  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_nx;
  logic [W-1:0]   w_mut_n;
  logic [W-1:0]   w_issue_idx;
  logic [W-1:0]   w_cnt_nxt;
  logic           w_skip;
  logic           w_clear;
  logic           w_upd;

  assign w_prod    = {{W{1'b0}}, r_pop} * {{W{1'b0}}, r_xfrac};
  assign w_nx      = w_prod[2*W-1:W];
  assign w_cnt_nxt = r_cnt + ONE;

`ifdef GA_ELITISM_EN
  // the elite individual is never crossed or mutated, so MUT has one item fewer
  assign w_skip  = (r_idx == best_idx);
  assign w_mut_n = r_pop - ONE;
`else
  assign w_skip  = 1'b0;
  assign w_mut_n = r_pop;
`endif

  // skipping is folded into the issued index so no idle cycle is spent on the elite
  assign w_issue_idx = w_skip ? (r_idx + ONE) : r_idx;
  assign w_clear     = (r_state == ST_IDLE) && start;
  assign w_upd       = (r_state == ST_EVAL) && eval_req && eval_ack;

  ga_min_tracker #(
    .IDX_W (W),
    .FIT_W (IND_FIT_LENGTH)
  ) u_min_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_upd    (w_upd),
    .i_fit    (eval_fit),
    .i_idx    (eval_idx),
    .o_min    (Min_fit_out),
    .o_argmin (best_idx)
  );

  // phase sequencer; a low req is raised next cycle, an acked req drops for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_num_gen  <= '0;
      r_pop      <= '0;
      r_xfrac    <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      load_ready <= 1'b0;
      eval_req   <= 1'b0;
      eval_idx   <= '0;
      xover_req  <= 1'b0;
      xover_idx  <= '0;
      mut_req    <= 1'b0;
      mut_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gen_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_gen <= Num_generations;
            r_pop     <= Pop_size;
            r_xfrac   <= crossoverFraction;
            r_cnt     <= '0;
            r_idx     <= '0;
            gen_cnt   <= '0;
            busy      <= 1'b1;
            if (Pop_size == '0) begin
              done    <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              load_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (load_valid && load_ready) begin
            if (w_cnt_nxt == r_pop) begin
              load_ready <= 1'b0;
              r_cnt      <= '0;
              r_idx      <= '0;
              r_state    <= ST_EVAL;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end

        ST_EVAL: begin
          if (!eval_req) begin
            eval_req <= 1'b1;
            eval_idx <= r_idx;
            r_idx    <= r_idx + ONE;
          end else if (eval_ack) begin
            eval_req <= 1'b0;
            if (w_cnt_nxt == r_pop) begin
              r_cnt <= '0;
              r_idx <= '0;
              if (gen_cnt == r_num_gen) begin
                done    <= 1'b1;
                r_state <= ST_DONE;
              end else if (w_nx != '0) begin
                r_state <= ST_XOVER;
              end else if (w_mut_n != '0) begin
                r_state <= ST_MUT;
              end else begin
                gen_cnt <= gen_cnt + ONE;
              end
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end

        ST_XOVER: begin
          if (!xover_req) begin
            xover_req <= 1'b1;
            xover_idx <= w_issue_idx;
            r_idx     <= w_issue_idx + ONE;
          end else if (xover_ack) begin
            xover_req <= 1'b0;
            if (w_cnt_nxt == w_nx) begin
              r_cnt <= '0;
              r_idx <= '0;
              if (w_mut_n != '0) begin
                r_state <= ST_MUT;
              end else begin
                gen_cnt <= gen_cnt + ONE;
                r_state <= ST_EVAL;
              end
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end

        ST_MUT: begin
          if (!mut_req) begin
            mut_req <= 1'b1;
            mut_idx <= w_issue_idx;
            r_idx   <= w_issue_idx + ONE;
          end else if (mut_ack) begin
            mut_req <= 1'b0;
            if (w_cnt_nxt == w_mut_n) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              gen_cnt <= gen_cnt + ONE;
              r_state <= ST_EVAL;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end

        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ga_gen_ctrl.sv
// tb/tb_ga_gen_ctrl.sv - randomized self-checking bench for ga_gen_ctrl against a request-list model
module tb_ga_gen_ctrl;

`ifdef GA_ELITISM_EN
  localparam bit ELIT = 1'b1;
`else
  localparam bit ELIT = 1'b0;
`endif
  localparam int FMAX = 1023;

  logic       clk, rst, start;
  logic [7:0] Num_generations, Pop_size, crossoverFraction;
  logic       load_valid, load_ready;
  logic       eval_req, eval_ack, xover_req, xover_ack, mut_req, mut_ack;
  logic [7:0] eval_idx, xover_idx, mut_idx;
  logic [9:0] eval_fit;
  logic       busy, done;
  logic [7:0] gen_cnt, best_idx;
  logic [9:0] Min_fit_out;

  ga_gen_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .Num_generations(Num_generations), .Pop_size(Pop_size), .crossoverFraction(crossoverFraction),
    .load_valid(load_valid), .load_ready(load_ready),
    .eval_req(eval_req), .eval_idx(eval_idx), .eval_ack(eval_ack), .eval_fit(eval_fit),
    .xover_req(xover_req), .xover_idx(xover_idx), .xover_ack(xover_ack),
    .mut_req(mut_req), .mut_idx(mut_idx), .mut_ack(mut_ack),
    .busy(busy), .done(done), .gen_cnt(gen_cnt), .Min_fit_out(Min_fit_out), .best_idx(best_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int kind;    // 0 eval, 1 xover, 2 mut
    int idx;
    int fit;
    bit endgen;  // last mutation of a generation
  } item_t;

  item_t exp_q[$];
  int    fit_tab[0:1023];
  int    total, bad;

  int exp_ne, exp_nx, exp_nm, exp_gen, exp_min, exp_best;
  int model_gen, model_min, model_best;
  int n_eval, n_xov, n_mut, n_done, n_lb, cfg_p;
  int hold_len, max_hold, wait_cnt, fix_delay;
  bit run_on, run_done, first_cyc, load_phase, post_done;
  bit hs_pend, lb_pend, expect_next, prev_req;
  int prev_kind, prev_idx;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_load_ready"}, int'(load_ready), 0);
    check({tag, "_reqs"}, int'({eval_req, xover_req, mut_req}), 0);
    check({tag, "_idxs"}, int'(eval_idx) + int'(xover_idx) + int'(mut_idx), 0);
    check({tag, "_busy_done"}, int'({busy, done}), 0);
    check({tag, "_gen_cnt"}, int'(gen_cnt), 0);
    check({tag, "_min_fit"}, int'(Min_fit_out), 0);
    check({tag, "_best_idx"}, int'(best_idx), 0);
  endtask

  task automatic fill_fit();
    for (int i = 0; i < 1024; i++) fit_tab[i] = $urandom_range(0, 63);
  endtask

  // Expected request order derived from the generation rules, not from the controller's states.
  task automatic build_model(input int p, input int g, input int f);
    int nx, mn, bi;
    int lst[$];
    item_t it;
    exp_q.delete();
    exp_ne = 0; exp_nx = 0; exp_nm = 0;
    mn = FMAX; bi = 0;
    nx = ((p * f) & 16'hFFFF) >> 8;
    for (int gi = 0; gi <= g; gi++) begin
      for (int i = 0; i < p; i++) begin
        it.kind = 0; it.idx = i; it.fit = fit_tab[gi*256 + i]; it.endgen = 1'b0;
        exp_q.push_back(it); exp_ne++;
        if (it.fit < mn) begin mn = it.fit; bi = i; end
      end
      if (gi < g && p > 0) begin
        lst.delete();
        for (int i = 0; i < p; i++) if (!(ELIT && i == bi)) lst.push_back(i);
        for (int k = 0; k < nx; k++) begin
          it.kind = 1; it.idx = lst[k]; it.fit = 0; it.endgen = 1'b0;
          exp_q.push_back(it); exp_nx++;
        end
        for (int k = 0; k < lst.size(); k++) begin
          it.kind = 2; it.idx = lst[k]; it.fit = 0; it.endgen = (k == lst.size() - 1);
          exp_q.push_back(it); exp_nm++;
        end
      end
    end
    exp_gen  = (p > 0) ? g : 0;
    exp_min  = mn;
    exp_best = bi;
  endtask

  task automatic start_case(input int p, input int g, input int f, input bit poke);
    build_model(p, g, f);
    n_eval = 0; n_xov = 0; n_mut = 0; n_done = 0; n_lb = 0; cfg_p = p;
    model_gen = 0; model_min = FMAX; model_best = 0;
    hs_pend = 0; lb_pend = 0; expect_next = 0; prev_req = 0; post_done = 0;
    run_done = 0; first_cyc = 1; load_phase = (p > 0); hold_len = 0; max_hold = 0;
    Pop_size = 8'(p); Num_generations = 8'(g); crossoverFraction = 8'(f);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    run_on = 1'b1;
    if (poke) begin
      for (int c = 0; c < 2000 && !eval_req; c++) @(negedge clk);
      check("poke_in_eval", int'(eval_req), 1);
      start = 1'b1;
      Pop_size = 8'(p + 3); Num_generations = 8'(g + 1); crossoverFraction = 8'(255 - f);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic finish_case();
    for (int c = 0; c < 20000 && !run_done; c++) @(negedge clk);
    check("run_completes", int'(run_done), 1);
    if (!run_done) begin
      run_on = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check("eval_count", n_eval, exp_ne);
      check("xover_count", n_xov, exp_nx);
      check("mut_count", n_mut, exp_nm);
      check("done_pulses", n_done, 1);
      repeat (3) @(negedge clk);
      check("hold_gen_cnt", int'(gen_cnt), exp_gen);
      check("hold_min_fit", int'(Min_fit_out), exp_min);
      check("hold_best_idx", int'(best_idx), exp_best);
      check("idle_busy", int'(busy), 0);
    end
  endtask

  // Compare process: every cycle of a run, checks outputs against the model and drives the responders.
  initial begin
    int nreq, kind, cidx;
    bit finish, exp_now, gap_now;
    item_t it;
    eval_ack = 0; xover_ack = 0; mut_ack = 0; eval_fit = 0; load_valid = 0;
    forever begin
      @(negedge clk);
      if (!run_on) begin
        eval_ack = 0; xover_ack = 0; mut_ack = 0; load_valid = 0;
        continue;
      end
      nreq = int'(eval_req) + int'(xover_req) + int'(mut_req);
      kind = eval_req ? 0 : (xover_req ? 1 : 2);
      cidx = eval_req ? int'(eval_idx) : (xover_req ? int'(xover_idx) : int'(mut_idx));
      if (done) n_done++;
      if (post_done) begin
        check("after_done_done", int'(done), 0);
        check("after_done_busy", int'(busy), 0);
        eval_ack = 0; xover_ack = 0; mut_ack = 0; load_valid = 0;
        run_on = 0; run_done = 1;
        continue;
      end
      finish = 0; gap_now = 0;
      exp_now = expect_next; expect_next = 0;
      if (first_cyc) begin
        first_cyc = 0;
        if (exp_q.size() == 0) finish = 1;
      end
      if (lb_pend) begin
        lb_pend = 0; n_lb++;
        if (n_lb == cfg_p) begin load_phase = 0; gap_now = 1; expect_next = 1; end
      end
      if (hs_pend) begin
        hs_pend = 0; gap_now = 1;
        it = exp_q.pop_front();
        if (it.kind == 0) begin
          n_eval++;
          if (it.fit < model_min) begin model_min = it.fit; model_best = it.idx; end
        end else if (it.kind == 1) n_xov++;
        else n_mut++;
        if (it.endgen) model_gen++;
        if (exp_q.size() == 0) finish = 1; else expect_next = 1;
      end
      check("single_req", int'(nreq <= 1), 1);
      if (exp_now) check("req_after_gap", nreq, 1);
      if (gap_now) check("gap_cycle", nreq, 0);
      check("done", int'(done), int'(finish));
      check("busy", int'(busy), 1);
      check("load_ready", int'(load_ready), int'(load_phase));
      check("gen_cnt", int'(gen_cnt), model_gen);
      check("min_fit", int'(Min_fit_out), model_min);
      check("best_idx", int'(best_idx), model_best);
      if (nreq == 1) begin
        if (!prev_req) begin
          check("req_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            check("req_kind", kind, exp_q[0].kind);
            check("req_idx", cidx, exp_q[0].idx);
          end
          hold_len = 1;
          wait_cnt = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 3);
        end else begin
          check("held_kind", kind, prev_kind);
          check("held_idx", cidx, prev_idx);
          hold_len++;
        end
        if (hold_len > max_hold) max_hold = hold_len;
      end
      prev_req = (nreq == 1); prev_kind = kind; prev_idx = cidx;
      if (finish) post_done = 1;
      load_valid = 1'($urandom_range(0, 1));
      lb_pend = load_ready && load_valid;
      if (nreq == 1) begin
        eval_ack = 0; xover_ack = 0; mut_ack = 0;
        if (wait_cnt == 0 && exp_q.size() > 0) begin
          if (kind == 0) begin eval_ack = 1; eval_fit = 10'(exp_q[0].fit); end
          else if (kind == 1) xover_ack = 1;
          else mut_ack = 1;
          hs_pend = 1;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
      end else begin
        eval_ack = ($urandom_range(0, 3) == 0);
        xover_ack = ($urandom_range(0, 3) == 0);
        mut_ack = ($urandom_range(0, 3) == 0);
        eval_fit = 10'($urandom_range(0, 7));
      end
    end
  end

  initial begin
    total = 0; bad = 0; fix_delay = -1; run_on = 0; run_done = 0;
    rst = 1'b1; start = 1'b0;
    Num_generations = 0; Pop_size = 0; crossoverFraction = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // start accepted on the first cycle after reset; single EVAL pass with a tie on fitness 3
    fill_fit();
    fit_tab[0] = 9; fit_tab[1] = 3; fit_tab[2] = 7; fit_tab[3] = 3;
    start_case(4, 0, 0, 0);
    finish_case();
    check("g0_min_fit", int'(Min_fit_out), 3);
    check("g0_best_idx", int'(best_idx), 1);
    check("g0_evals", n_eval, 4);
    check("g0_xover_mut", n_xov + n_mut, 0);
    check("g0_done_pulses", n_done, 1);

    fill_fit();
    start_case(8, 2, 128, 0);
    finish_case();
    check("p8_evals", n_eval, 24);
    check("p8_xovers", n_xov, 8);
    check("p8_muts", n_mut, ELIT ? 14 : 16);
    check("p8_gen_cnt", int'(gen_cnt), 2);

    start_case(0, 5, 77, 0);
    finish_case();
    check("p0_reqs", n_eval + n_xov + n_mut, 0);
    check("p0_done_pulses", n_done, 1);
    check("p0_min_fit", int'(Min_fit_out), FMAX);

    fill_fit();
    fix_delay = 5;
    start_case(3, 1, 100, 0);
    finish_case();
    check("delay5_hold_cycles", max_hold, 6);
    fix_delay = -1;

    fill_fit();
    start_case(5, 1, 200, 1);
    finish_case();

    // reset in the middle of mutation, then a fresh small run
    fill_fit();
    start_case(4, 2, 128, 0);
    for (int c = 0; c < 2000 && !mut_req; c++) @(negedge clk);
    check("reached_mut", int'(mut_req), 1);
    #2;
    run_on = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("mid_mut_rst");
    @(negedge clk);
    rst = 1'b0;
    fill_fit();
    start_case(2, 1, 200, 0);
    finish_case();
    check("after_rst_evals", n_eval, 4);
    check("after_rst_gen_cnt", int'(gen_cnt), 1);

    for (int r = 0; r < 6; r++) begin
      fill_fit();
      start_case($urandom_range(2, 12), $urandom_range(0, 3), $urandom_range(0, 255), r[0]);
      finish_case();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
